// File: rtl/ram_pkg.sv
// Shared constants and byte helpers for the ram_sdp family of memories.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Helpers operate at a fixed maximum width; callers cast to their own width.
    localparam int MAX_BYTES = 64;
    localparam int MAX_W     = 8 * MAX_BYTES;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic [MAX_W-1:0] strb_merge(input logic [MAX_W-1:0]     old_w,
                                                    input logic [MAX_W-1:0]     new_w,
                                                    input logic [MAX_BYTES-1:0] strb);
        logic [MAX_W-1:0] m;
        m = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_sdp_rdpipe.sv
// Read-result delay line: valid/err/payload registered READ_LATENCY times, payload held while idle.
module ram_sdp_rdpipe #(
    parameter int W            = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    input  logic         i_err,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic         o_err,
    output logic [W-1:0] o_data
);

    logic         r_vld  [READ_LATENCY];
    logic         r_err  [READ_LATENCY];
    logic [W-1:0] r_data [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_vld[s]  <= 1'b0;
                r_err[s]  <= 1'b0;
                r_data[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_err[0] <= i_vld & i_err;
            if (i_vld) r_data[0] <= i_data;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_err[s] <= r_err[s-1];
                if (r_vld[s-1]) r_data[s] <= r_data[s-1];
            end
        end
    end

    assign o_vld  = r_vld[READ_LATENCY-1];
    assign o_err  = r_err[READ_LATENCY-1];
    assign o_data = r_data[READ_LATENCY-1];

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM with byte strobes, range checks and configurable read latency.
// Optional per-byte parity storage and checking when RAM_SDP_PARITY_EN is defined.
module ram_sdp
    import ram_pkg::*;
#(
    parameter int    DATA_WIDTH    = 8,
    parameter int    ADDR_WIDTH    = 16,
    parameter int    DEPTH         = 256,
    parameter int    READ_LATENCY  = 1,
    parameter int    RDW_MODE      = 0,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_err,
    output logic                    wr_err
`ifdef RAM_SDP_PARITY_EN
    ,
    output logic [DATA_WIDTH/8-1:0] rd_perr
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_SDP_PARITY_EN
    localparam int PW    = DATA_WIDTH + NB;
`else
    localparam int PW    = DATA_WIDTH;
`endif
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_wr_err;

    logic                  w_wr_in, w_rd_in, w_wr_ok, w_rdw_fwd;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic [DATA_WIDTH-1:0] w_wr_word, w_rd_word;
    logic [PW-1:0]         w_rd_pay, w_out_pay;

    assign w_wr_in   = {1'b0, wr_addr} < DEPTH_C;
    assign w_rd_in   = {1'b0, rd_addr} < DEPTH_C;
    assign w_wr_ok   = rst_n & wr_en & w_wr_in;
    assign w_wr_idx  = wr_addr[IDX_W-1:0];
    assign w_rd_idx  = rd_addr[IDX_W-1:0];
    assign w_rdw_fwd = (RDW_MODE == RDW_WRITE_FIRST) && w_wr_ok && (wr_addr == rd_addr);
    assign w_wr_word = DATA_WIDTH'(strb_merge(MAX_W'(r_mem[w_wr_idx]), MAX_W'(wr_data),
                                              MAX_BYTES'(wr_strb)));

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in) w_rd_word = w_rdw_fwd ? w_wr_word : r_mem[w_rd_idx];
    end

`ifdef RAM_SDP_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_wr_par, w_rd_par, w_rd_perr;

    always_comb begin
        w_wr_par = r_par[w_wr_idx];
        for (int i = 0; i < NB; i++) begin
            if (wr_strb[i]) w_wr_par[i] = byte_parity(wr_data[8*i +: 8]);
        end
    end

    always_comb begin
        w_rd_par = '0;
        if (w_rd_in) w_rd_par = w_rdw_fwd ? w_wr_par : r_par[w_rd_idx];
        for (int i = 0; i < NB; i++) begin
            w_rd_perr[i] = w_rd_in & (byte_parity(w_rd_word[8*i +: 8]) ^ w_rd_par[i]);
        end
    end

    assign w_rd_pay = {w_rd_perr, w_rd_word};
`else
    assign w_rd_pay = w_rd_word;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx] <= w_wr_word;
`ifdef RAM_SDP_PARITY_EN
            r_par[w_wr_idx] <= w_wr_par;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_wr_err <= 1'b0;
        else        r_wr_err <= wr_en & ~w_wr_in;
    end

    ram_sdp_rdpipe #(
        .W            (PW),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (rd_en),
        .i_err  (~w_rd_in),
        .i_data (w_rd_pay),
        .o_vld  (rd_valid),
        .o_err  (rd_err),
        .o_data (w_out_pay)
    );

`ifdef RAM_SDP_PARITY_EN
    assign {rd_perr, rd_data} = w_out_pay;
`else
    assign rd_data = w_out_pay;
`endif
    assign wr_err = r_wr_err;

endmodule
